// File: rtl/bcp_issue_if.sv
// Handshake bundle between control, the clause-eval pipeline and bcp_issue.
// slave = the BCP responder itself, master = everything that drives it.
interface bcp_issue_if #(
    parameter int CT_BITS  = 8,
    parameter int VAR_BITS = 8
);
    logic                bcp_en;
    logic [CT_BITS-1:0]  start_clause;
    logic [CT_BITS-1:0]  end_clause;
    logic                bcp_busy;
    logic                conflict;
    logic [CT_BITS-1:0]  bcp_clause_idx;
    logic                issue_valid;
    logic                eval_valid;
    logic                eval_unit;
    logic                eval_conflict;
    logic [VAR_BITS-1:0] eval_var;
    logic                eval_val;
    logic                full_imply;
    logic                push_imply;
    logic [VAR_BITS-1:0] var_in_imply;
    logic                val_in_imply;
    logic                imply_overflow;

    modport slave (
        input  bcp_en, start_clause, end_clause,
        input  eval_valid, eval_unit, eval_conflict,
        input  eval_var, eval_val, full_imply,
        output bcp_busy, conflict, bcp_clause_idx, issue_valid,
        output push_imply, var_in_imply, val_in_imply,
        output imply_overflow
    );

    modport master (
        output bcp_en, start_clause, end_clause,
        output eval_valid, eval_unit, eval_conflict,
        output eval_var, eval_val, full_imply,
        input  bcp_busy, conflict, bcp_clause_idx, issue_valid,
        input  push_imply, var_in_imply, val_in_imply,
        input  imply_overflow
    );
endinterface

// File: rtl/bcp_issue.sv
// BCP clause-walk issuer: streams clause indices out, folds eval results back.
// Define BCP_IMPLY_DEDUP_EN to suppress repeated implications within a walk.
module bcp_issue #(
    parameter int CT_BITS         = 8,
    parameter int VAR_BITS        = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clock,
    input  logic        reset,
    bcp_issue_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [3:0]         MAX_OUT = 4'(MAX_OUTSTANDING);
    localparam logic [CT_BITS-1:0] CT_ONE  = CT_BITS'(1);

    state_t             r_state;
    logic [CT_BITS-1:0] r_cur;
    logic [CT_BITS-1:0] r_end;
    logic [3:0]         r_out;
    logic               r_busy;
    logic               r_conflict;
    logic               r_ovf;
    logic               r_fin;

    logic               w_active;
    logic               w_res;
    logic               w_live;
    logic               w_dup;
    logic               w_opp;
    logic               w_hit;
    logic               w_unit;
    logic               w_push;
    logic               w_ovf;
    logic               w_stop;
    logic               w_issue;
    logic [3:0]         w_out_nxt;
    logic [CT_BITS-1:0] w_cur_nxt;

`ifdef BCP_IMPLY_DEDUP_EN
    logic                r_last_vld;
    logic [VAR_BITS-1:0] r_last_var;
    logic                r_last_val;
    logic                w_same;

    assign w_same = r_last_vld && (bus.eval_var == r_last_var);
    assign w_dup  = w_same && (bus.eval_val == r_last_val);
    assign w_opp  = w_same && (bus.eval_val != r_last_val);
`else
    assign w_dup  = 1'b0;
    assign w_opp  = 1'b0;
`endif

    // Results only count while a walk has something in flight.
    assign w_active = reset &&
                      (r_state == S_ISSUE || r_state == S_DRAIN);
    assign w_res    = w_active && bus.eval_valid && (r_out != 4'd0);
    assign w_live   = w_res && !r_conflict;

    assign w_hit  = w_live &&
                    (bus.eval_conflict || (bus.eval_unit && w_opp));
    assign w_unit = w_live && !bus.eval_conflict && bus.eval_unit &&
                    !w_opp && !w_dup;
    assign w_push = w_unit && !bus.full_imply;
    assign w_ovf  = w_unit && bus.full_imply;
    assign w_stop = w_hit || w_ovf;

    // A result that ends the walk also blocks an issue in the same cycle.
    assign w_issue = reset && (r_state == S_ISSUE) &&
                     (r_cur < r_end) && (r_out < MAX_OUT) &&
                     !bus.full_imply && !w_stop;

    assign w_out_nxt = r_out + {3'd0, w_issue} - {3'd0, w_res};
    assign w_cur_nxt = r_cur + CT_ONE;

    assign bus.issue_valid    = w_issue;
    assign bus.bcp_clause_idx = w_issue ? r_cur : '0;
    assign bus.push_imply     = w_push;
    assign bus.var_in_imply   = w_push ? bus.eval_var : '0;
    assign bus.val_in_imply   = w_push && bus.eval_val;
    assign bus.bcp_busy       = r_busy;
    assign bus.conflict       = r_conflict;
    assign bus.imply_overflow = r_ovf;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cur      <= '0;
            r_end      <= '0;
            r_out      <= '0;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
            r_ovf      <= 1'b0;
            r_fin      <= 1'b0;
`ifdef BCP_IMPLY_DEDUP_EN
            r_last_vld <= 1'b0;
            r_last_var <= '0;
            r_last_val <= 1'b0;
`endif
        end else begin
            if (w_active) r_out <= w_out_nxt;
            if (w_issue)  r_cur <= w_cur_nxt;
            if (w_stop)   r_conflict <= 1'b1;
            if (w_ovf)    r_ovf <= 1'b1;
`ifdef BCP_IMPLY_DEDUP_EN
            if (w_push) begin
                r_last_vld <= 1'b1;
                r_last_var <= bus.eval_var;
                r_last_val <= bus.eval_val;
            end
`endif
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.bcp_en) begin
                        r_cur      <= bus.start_clause;
                        r_end      <= bus.end_clause;
                        r_out      <= '0;
                        r_conflict <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_fin      <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef BCP_IMPLY_DEDUP_EN
                        r_last_vld <= 1'b0;
`endif
                        if (bus.start_clause >= bus.end_clause)
                            r_state <= S_DRAIN;
                        else
                            r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_stop || (w_issue && w_cur_nxt == r_end))
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // One settle cycle after the pipe empties, then release.
                    if (r_fin) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_fin   <= 1'b0;
                    end else if (w_out_nxt == 4'd0) begin
                        r_fin <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcp_issue.sv
// Directed bench for bcp_issue: a latency-configurable in-order responder
// plus a negedge monitor logging issues, pushes and busy cycles.
module tb_bcp_issue;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bcp_issue_if #(.CT_BITS(8), .VAR_BITS(8)) bus ();

    bcp_issue #(
        .CT_BITS(8),
        .VAR_BITS(8),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus(bus.slave)
    );

`ifdef BCP_IMPLY_DEDUP_EN
    localparam int EXP_DUP_PUSH  = 1;
    localparam int EXP_OPP_PUSH  = 1;
    localparam int EXP_OPP_CONF  = 1;
`else
    localparam int EXP_DUP_PUSH  = 2;
    localparam int EXP_OPP_PUSH  = 2;
    localparam int EXP_OPP_CONF  = 0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic       tab_unit [256];
    logic       tab_conf [256];
    logic [7:0] tab_var  [256];
    logic       tab_val  [256];

    int lat = 1;
    bit flush = 0;
    bit inj = 0;
    int cyc = 0;
    int inflight = 0;
    int max_inflight = 0;
    int busy_cnt = 0;
    int k;
    int iss_q[$];
    int iss_cyc[$];
    int pend_idx[$];
    int pend_due[$];
    logic [8:0] push_q[$];

    // Responder drives results mid-cycle, monitor samples 1 time unit later.
    always @(negedge clk) begin
        cyc = cyc + 1;
        bus.eval_valid    = 1'b0;
        bus.eval_unit     = 1'b0;
        bus.eval_conflict = 1'b0;
        bus.eval_var      = 8'd0;
        bus.eval_val      = 1'b0;
        if (flush) begin
            pend_idx.delete();
            pend_due.delete();
            inflight = 0;
        end else if (inj) begin
            bus.eval_valid = 1'b1;
            bus.eval_unit  = 1'b1;
            bus.eval_var   = 8'd9;
            bus.eval_val   = 1'b1;
        end else if (pend_idx.size() > 0 && pend_due[0] == cyc) begin
            k = pend_idx.pop_front();
            void'(pend_due.pop_front());
            bus.eval_valid    = 1'b1;
            bus.eval_unit     = tab_unit[k];
            bus.eval_conflict = tab_conf[k];
            bus.eval_var      = tab_var[k];
            bus.eval_val      = tab_val[k];
        end
        #1;
        if (bus.eval_valid && inflight > 0) inflight = inflight - 1;
        if (bus.issue_valid && !flush) begin
            iss_q.push_back(int'(bus.bcp_clause_idx));
            iss_cyc.push_back(cyc);
            pend_idx.push_back(int'(bus.bcp_clause_idx));
            pend_due.push_back(cyc + lat);
            inflight = inflight + 1;
            if (inflight > max_inflight) max_inflight = inflight;
        end
        if (bus.push_imply)
            push_q.push_back({bus.var_in_imply, bus.val_in_imply});
        if (bus.bcp_busy) busy_cnt = busy_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_tab;
        for (int i = 0; i < 256; i++) begin
            tab_unit[i] = 1'b0;
            tab_conf[i] = 1'b0;
            tab_var[i]  = 8'd0;
            tab_val[i]  = 1'b0;
        end
    endtask

    task automatic clear_logs;
        iss_q.delete();
        iss_cyc.delete();
        push_q.delete();
        max_inflight = 0;
        busy_cnt = 0;
    endtask

    task automatic start_walk(input int s, input int e, input int l);
        lat = l;
        clear_logs();
        bus.start_clause = 8'(s);
        bus.end_clause   = 8'(e);
        bus.bcp_en = 1'b1;
        tick();
        bus.bcp_en = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 300; i++) begin
            if (!bus.bcp_busy) break;
            tick();
        end
        n_tests++;
        if (bus.bcp_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout: busy got %0b want 0", nm, bus.bcp_busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        n_tests++; if (bus.bcp_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", bus.bcp_busy); end
        n_tests++; if (bus.conflict !== 1'b0) begin n_fail++; $display("FAIL rst_conflict: got %0b want 0", bus.conflict); end
        n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL rst_issue: got %0b want 0", bus.issue_valid); end
        n_tests++; if (bus.push_imply !== 1'b0) begin n_fail++; $display("FAIL rst_push: got %0b want 0", bus.push_imply); end
        n_tests++; if (bus.imply_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %0b want 0", bus.imply_overflow); end
        n_tests++; if (bus.bcp_clause_idx !== 8'd0) begin n_fail++; $display("FAIL rst_idx: got %0d want 0", bus.bcp_clause_idx); end
        n_tests++; if (bus.var_in_imply !== 8'd0) begin n_fail++; $display("FAIL rst_var: got %0d want 0", bus.var_in_imply); end
        n_tests++; if (bus.val_in_imply !== 1'b0) begin n_fail++; $display("FAIL rst_val: got %0b want 0", bus.val_in_imply); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_empty;
        clear_tab();
        start_walk(5, 5, 1);
        wait_idle("empty");
        n_tests++; if (iss_q.size() !== 0) begin n_fail++; $display("FAIL empty_issues: got %0d want 0", iss_q.size()); end
        n_tests++; if (busy_cnt !== 2) begin n_fail++; $display("FAIL empty_busy_cycles: got %0d want 2", busy_cnt); end
        n_tests++; if (bus.conflict !== 1'b0) begin n_fail++; $display("FAIL empty_conflict: got %0b want 0", bus.conflict); end
    endtask

    task automatic test_walk3;
        int got;
        clear_tab();
        tab_unit[1] = 1'b1;
        tab_var[1]  = 8'd2;
        tab_val[1]  = 1'b0;
        start_walk(0, 3, 1);
        wait_idle("walk3");
        n_tests++; if (iss_q.size() !== 3) begin n_fail++; $display("FAIL walk3_count: got %0d want 3", iss_q.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < iss_q.size()) ? iss_q[i] : -1;
            n_tests++; if (got !== i) begin n_fail++; $display("FAIL walk3_idx%0d: got %0d want %0d", i, got, i); end
        end
        got = (iss_cyc.size() >= 3) ? iss_cyc[2] - iss_cyc[0] : -1;
        n_tests++; if (got !== 2) begin n_fail++; $display("FAIL walk3_span: got %0d want 2", got); end
        n_tests++; if (push_q.size() !== 1) begin n_fail++; $display("FAIL walk3_push_count: got %0d want 1", push_q.size()); end
        got = (push_q.size() > 0) ? int'(push_q[0]) : -1;
        n_tests++; if (got !== 4) begin n_fail++; $display("FAIL walk3_push_data: got %0h want 4", got); end
        n_tests++; if (bus.conflict !== 1'b0) begin n_fail++; $display("FAIL walk3_conflict: got %0b want 0", bus.conflict); end
        n_tests++; if (busy_cnt !== 5) begin n_fail++; $display("FAIL walk3_busy_cycles: got %0d want 5", busy_cnt); end
    endtask

    task automatic test_backpressure;
        int got;
        clear_tab();
        start_walk(0, 8, 5);
        wait_idle("bp");
        n_tests++; if (iss_q.size() !== 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", iss_q.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < iss_q.size()) ? iss_q[i] : -1;
            n_tests++; if (got !== i) begin n_fail++; $display("FAIL bp_idx%0d: got %0d want %0d", i, got, i); end
        end
        n_tests++; if (max_inflight !== 4) begin n_fail++; $display("FAIL bp_max_inflight: got %0d want 4", max_inflight); end
        got = (iss_cyc.size() >= 5) ? iss_cyc[4] - iss_cyc[3] : -1;
        n_tests++; if (got !== 3) begin n_fail++; $display("FAIL bp_stall_gap: got %0d want 3", got); end
    endtask

    task automatic test_conflict;
        clear_tab();
        tab_conf[1] = 1'b1;
        tab_unit[2] = 1'b1; tab_var[2] = 8'd5; tab_val[2] = 1'b1;
        tab_unit[3] = 1'b1; tab_var[3] = 8'd6; tab_val[3] = 1'b1;
        start_walk(0, 6, 3);
        wait_idle("conf");
        n_tests++; if (iss_q.size() !== 4) begin n_fail++; $display("FAIL conf_issues: got %0d want 4", iss_q.size()); end
        n_tests++; if (push_q.size() !== 0) begin n_fail++; $display("FAIL conf_pushes: got %0d want 0", push_q.size()); end
        n_tests++; if (bus.conflict !== 1'b1) begin n_fail++; $display("FAIL conf_flag: got %0b want 1", bus.conflict); end
        repeat (4) tick();
        n_tests++; if (bus.conflict !== 1'b1) begin n_fail++; $display("FAIL conf_sticky: got %0b want 1", bus.conflict); end
        n_tests++; if (bus.bcp_busy !== 1'b0) begin n_fail++; $display("FAIL conf_idle: got %0b want 0", bus.bcp_busy); end
    endtask

    task automatic test_overflow;
        clear_tab();
        tab_unit[0] = 1'b1; tab_var[0] = 8'd3; tab_val[0] = 1'b1;
        start_walk(0, 2, 1);
        tick();
        bus.full_imply = 1'b1;
        wait_idle("ovf");
        bus.full_imply = 1'b0;
        n_tests++; if (bus.imply_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", bus.imply_overflow); end
        n_tests++; if (bus.conflict !== 1'b1) begin n_fail++; $display("FAIL ovf_conflict: got %0b want 1", bus.conflict); end
        n_tests++; if (push_q.size() !== 0) begin n_fail++; $display("FAIL ovf_pushes: got %0d want 0", push_q.size()); end
        n_tests++; if (iss_q.size() !== 1) begin n_fail++; $display("FAIL ovf_issues: got %0d want 1", iss_q.size()); end
        start_walk(3, 3, 1);
        wait_idle("ovf_clear");
        n_tests++; if (bus.imply_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %0b want 0", bus.imply_overflow); end
        n_tests++; if (bus.conflict !== 1'b0) begin n_fail++; $display("FAIL ovf_conf_cleared: got %0b want 0", bus.conflict); end
    endtask

    task automatic test_reset_mid;
        int got;
        clear_tab();
        start_walk(0, 10, 5);
        repeat (3) tick();
        n_tests++; if (iss_q.size() !== 3) begin n_fail++; $display("FAIL rmid_outstanding: got %0d want 3", iss_q.size()); end
        rst_n = 1'b0;
        flush = 1'b1;
        tick();
        n_tests++; if (bus.bcp_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %0b want 0", bus.bcp_busy); end
        n_tests++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_issue: got %0b want 0", bus.issue_valid); end
        n_tests++; if (bus.bcp_clause_idx !== 8'd0) begin n_fail++; $display("FAIL rmid_idx: got %0d want 0", bus.bcp_clause_idx); end
        n_tests++; if (bus.conflict !== 1'b0) begin n_fail++; $display("FAIL rmid_conflict: got %0b want 0", bus.conflict); end
        rst_n = 1'b1;
        flush = 1'b0;
        tick();
        start_walk(4, 6, 1);
        wait_idle("rmid_fresh");
        n_tests++; if (iss_q.size() !== 2) begin n_fail++; $display("FAIL rmid_fresh_count: got %0d want 2", iss_q.size()); end
        got = (iss_q.size() > 0) ? iss_q[0] : -1;
        n_tests++; if (got !== 4) begin n_fail++; $display("FAIL rmid_fresh_first: got %0d want 4", got); end
        n_tests++; if (busy_cnt !== 4) begin n_fail++; $display("FAIL rmid_fresh_busy: got %0d want 4", busy_cnt); end
    endtask

    task automatic test_stray_eval;
        clear_tab();
        clear_logs();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        n_tests++; if (push_q.size() !== 0) begin n_fail++; $display("FAIL stray_push: got %0d want 0", push_q.size()); end
        start_walk(0, 1, 1);
        wait_idle("stray");
        n_tests++; if (iss_q.size() !== 1) begin n_fail++; $display("FAIL stray_issue: got %0d want 1", iss_q.size()); end
        n_tests++; if (busy_cnt !== 3) begin n_fail++; $display("FAIL stray_busy: got %0d want 3", busy_cnt); end
    endtask

    task automatic test_dedup;
        clear_tab();
        tab_unit[0] = 1'b1; tab_var[0] = 8'd7; tab_val[0] = 1'b1;
        tab_unit[1] = 1'b1; tab_var[1] = 8'd7; tab_val[1] = 1'b1;
        start_walk(0, 2, 1);
        wait_idle("dup");
        n_tests++; if (push_q.size() !== EXP_DUP_PUSH) begin n_fail++; $display("FAIL dup_pushes: got %0d want %0d", push_q.size(), EXP_DUP_PUSH); end
        n_tests++; if (bus.conflict !== 1'b0) begin n_fail++; $display("FAIL dup_conflict: got %0b want 0", bus.conflict); end
        tab_val[1] = 1'b0;
        start_walk(0, 2, 1);
        wait_idle("opp");
        n_tests++; if (push_q.size() !== EXP_OPP_PUSH) begin n_fail++; $display("FAIL opp_pushes: got %0d want %0d", push_q.size(), EXP_OPP_PUSH); end
        n_tests++; if (int'(bus.conflict) !== EXP_OPP_CONF) begin n_fail++; $display("FAIL opp_conflict: got %0b want %0d", bus.conflict, EXP_OPP_CONF); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.bcp_en = 1'b0;
        bus.start_clause = 8'd0;
        bus.end_clause = 8'd0;
        bus.full_imply = 1'b0;
        clear_tab();
        test_reset();
        test_empty();
        test_walk3();
        test_backpressure();
        test_conflict();
        test_overflow();
        test_reset_mid();
        test_stray_eval();
        test_dedup();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
